execute_stage: RTL and testbench

Execute stage of the 5-stage RV32 pipeline, sitting between the ID/EX register and the memory stage. It applies forwarding to both operands, computes the ALU result, resolves branches and jumps, and registers everything into the EX/MEM pipeline register that feeds the memory stage. It also hosts an iterative unsigned multiply/divide unit (MUL, MULHU, DIVU, REMU). While that unit runs, the stage raises a stall request and injects bubbles downstream.

---
 rtl/riscv_pkg.sv | 55 +++++
 rtl/muldiv_unit.sv | 91 +++++++++
 rtl/execute_stage.sv | 131 +++++++++++++
 tb/tb_execute_stage.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared encodings for the RV32 execute stage: ALU operation codes,
// M-extension operation codes, forwarding-select codes and the state type
// of the iterative multiply/divide unit. Also holds the forwarding mux
// helper used for both operands.
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_MUL   = 2'b00,
        MD_MULHU = 2'b01,
        MD_DIVU  = 2'b10,
        MD_REMU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    // Select code 11 is unused by the hazard unit and falls back to the
    // register-file value.
    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                                 input logic [XLEN-1:0] rf_val,
                                                 input logic [XLEN-1:0] w_val,
                                                 input logic [XLEN-1:0] m_val);
        logic [XLEN-1:0] r;
        case (sel)
            FWD_W:   r = w_val;
            FWD_M:   r = m_val;
            default: r = rf_val;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative unsigned multiply/divide (MUL, MULHU, DIVU, REMU). One
// shift-add or restoring-subtract step per cycle, 32 steps per operation.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           operation request (sampled only in IDLE)
//   op[1:0]         00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   a, b            operands (a = multiplier/dividend, b = multiplicand/divisor)
//   busy            high in IDLE with start pending, and throughout RUN
//   done            high for the single DONE cycle
//   result          result, valid while done is high
// ---------------------------------------------------------------------------
module muldiv_unit
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    md_state_e   state, state_next;
    logic [1:0]  op_q;
    logic [31:0] opnd_b;
    // Upper half: partial product / partial remainder.
    // Lower half: remaining multiplier bits / dividend bits becoming quotient.
    logic [63:0] prod;
    logic [4:0]  cnt;

    logic [32:0] mul_sum;
    logic [31:0] rem_shift;
    logic        div_ge;
    logic [31:0] div_rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= MD_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (start) state_next = MD_RUN;
            MD_RUN:  if (cnt == 5'd31) state_next = MD_DONE;
            MD_DONE: state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    always_comb begin
        mul_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd_b} : 33'd0);
        // Shift the next dividend bit into the partial remainder. The bit that
        // falls off the top (prod[63]) means the shifted value already exceeds
        // any 32-bit divisor; the subtraction is still exact modulo 2^32.
        rem_shift = {prod[62:32], prod[31]};
        div_ge    = prod[63] | (rem_shift >= opnd_b);
        div_rem   = div_ge ? (rem_shift - opnd_b) : rem_shift;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= 2'b00;
            opnd_b <= 32'd0;
            prod   <= 64'd0;
            cnt    <= 5'd0;
        end else if (state == MD_IDLE && start) begin
            op_q   <= op;
            opnd_b <= b;
            prod   <= {32'd0, a};
            cnt    <= 5'd0;
        end else if (state == MD_RUN) begin
            cnt <= cnt + 5'd1;
            if (!op_q[1]) prod <= {mul_sum, prod[31:1]};
            else          prod <= {div_rem, prod[30:0], div_ge};
        end
    end

    // MULHU and REMU both live in the upper half; MUL and DIVU in the lower.
    assign result = op_q[0] ? prod[63:32] : prod[31:0];
    assign done   = (state == MD_DONE);
    // Gated by reset so the stall request drops the moment reset asserts.
    assign busy   = rst & (((state == MD_IDLE) & start) | (state == MD_RUN));

endmodule

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
// Execute stage of the 5-stage RV32 pipeline: operand forwarding, ALU,
// beq/jal resolution, iterative M-extension unit and the EX/MEM register.
//
// Ports (E = inputs from ID/EX, M = registered outputs to memory stage):
//   clk, rst                          clock, asynchronous active-low reset
//   RegWriteE, MemWriteE, ResultSrcE  control, passed to M
//   ALUSrcE                           0: forwarded B, 1: Imm_Ext_E
//   BranchE, JumpE                    beq / jal
//   ALUControlE[2:0]                  ALU operation
//   MulDivE, MulDivOpE[1:0]           M-extension op and its kind
//   ForwardA_E, ForwardB_E            00 regfile, 01 ResultW, 10 ALU_ResultM
//   RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW   32-bit data
//   RD_E[4:0]                         destination register
//   PCSrcE, PCTargetE                 fetch redirect (combinational)
//   BusyE                             stall request (combinational)
//   RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM,
//   ALU_ResultM                       EX/MEM register outputs
// ---------------------------------------------------------------------------
module execute_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        ALUSrcE,
    input  logic        BranchE,
    input  logic        JumpE,
    input  logic [2:0]  ALUControlE,
    input  logic        MulDivE,
    input  logic [1:0]  MulDivOpE,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [31:0] ResultW,
    input  logic [4:0]  RD_E,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        BusyE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] PCPlus4M,
    output logic [31:0] WriteDataM,
    output logic [31:0] ALU_ResultM
);

    logic [31:0]        op_a;
    logic [31:0]        fwd_b;
    logic [31:0]        op_b;
    logic signed [31:0] op_a_s;
    logic signed [31:0] op_b_s;
    logic [31:0]        alu_result;
    logic               zero;
    logic               md_busy;
    logic               md_done;
    logic [31:0]        md_result;

    assign op_a   = fwd_mux(ForwardA_E, RD1_E, ResultW, ALU_ResultM);
    assign fwd_b  = fwd_mux(ForwardB_E, RD2_E, ResultW, ALU_ResultM);
    assign op_b   = ALUSrcE ? Imm_Ext_E : fwd_b;
    assign op_a_s = op_a;
    assign op_b_s = op_b;

    always_comb begin
        alu_result = 32'd0;
        case (ALUControlE)
            ALU_ADD: alu_result = op_a + op_b;
            ALU_SUB: alu_result = op_a - op_b;
            ALU_AND: alu_result = op_a & op_b;
            ALU_OR:  alu_result = op_a | op_b;
            ALU_XOR: alu_result = op_a ^ op_b;
            ALU_SLT: alu_result = {31'd0, (op_a_s < op_b_s)};
            default: alu_result = 32'd0;
        endcase
    end

    assign zero      = (alu_result == 32'd0);
    // The ALU sees the M-extension operands while MulDivE is set, so its
    // zero flag must not be allowed to redirect fetch.
    assign PCSrcE    = ((BranchE & zero) | JumpE) & ~MulDivE;
    assign PCTargetE = PCE + Imm_Ext_E;

    muldiv_unit u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (MulDivE),
        .op     (MulDivOpE),
        .a      (op_a),
        .b      (fwd_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    assign BusyE = md_busy;

    // EX/MEM boundary: bubble while busy (data fields hold), mul/div result
    // in DONE, ALU result otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= 5'd0;
            PCPlus4M    <= 32'd0;
            WriteDataM  <= 32'd0;
            ALU_ResultM <= 32'd0;
        end else if (md_busy) begin
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
        end else begin
            RegWriteM   <= RegWriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= fwd_b;
            ALU_ResultM <= md_done ? md_result : alu_result;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
// Self-checking bench for execute_stage: directed ALU/forwarding table,
// branch/jump checks, directed and random mul/div operations, randomized ALU
// traffic against a behavioural model, and reset during a multiply.
// ---------------------------------------------------------------------------
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE;
    logic [2:0]  ALUControlE;
    logic        MulDivE;
    logic [1:0]  MulDivOpE;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        BusyE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_m = 32'd0;   // model's view of ALU_ResultM

    execute_stage dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .ResultSrcE  (ResultSrcE),
        .ALUSrcE     (ALUSrcE),
        .BranchE     (BranchE),
        .JumpE       (JumpE),
        .ALUControlE (ALUControlE),
        .MulDivE     (MulDivE),
        .MulDivOpE   (MulDivOpE),
        .ForwardA_E  (ForwardA_E),
        .ForwardB_E  (ForwardB_E),
        .RD1_E       (RD1_E),
        .RD2_E       (RD2_E),
        .Imm_Ext_E   (Imm_Ext_E),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .ResultW     (ResultW),
        .RD_E        (RD_E),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .BusyE       (BusyE),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .PCPlus4M    (PCPlus4M),
        .WriteDataM  (WriteDataM),
        .ALU_ResultM (ALU_ResultM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        alusrc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] resw;
        logic [31:0] exp_alu;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vec [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural ALU straight from the operation table.
    function automatic logic [31:0] alu_ref(input logic [2:0] ctl, input logic [31:0] a,
                                            input logic [31:0] b);
        case (ctl)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Mul/div reference using full-width arithmetic.
    function automatic logic [31:0] md_ref(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] rf,
                                            input logic [31:0] w, input logic [31:0] m);
        if (sel == 2'd1) return w;
        if (sel == 2'd2) return m;
        return rf;
    endfunction

    task automatic drive_idle();
        RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; ALUSrcE = 0;
        BranchE = 0; JumpE = 0; ALUControlE = 3'd0; MulDivE = 0; MulDivOpE = 2'd0;
        ForwardA_E = 2'd0; ForwardB_E = 2'd0;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; ResultW = 0;
        RD_E = 5'd0;
    endtask

    // Issues one mul/div op with operand A arriving over the W forward path;
    // ResultW is scrambled once RUN starts to confirm operands were latched.
    task automatic run_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input string name);
        int n;
        int bub;
        drive_idle();
        MulDivE = 1; MulDivOpE = op; RegWriteE = 1; RD_E = rd;
        ForwardA_E = 2'd1; ResultW = a; RD1_E = ~a;
        ForwardB_E = 2'd0; RD2_E = b; Imm_Ext_E = ~b;
        #1;
        n = 0; bub = 0;
        while (BusyE === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
            if (n == 1) ResultW = ~a;
            if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0) bub++;
        end
        check({name, " busy cycles"}, n, 33);
        check({name, " bubble writes"}, bub, 0);
        @(posedge clk); #1;
        check({name, " result"}, ALU_ResultM, exp);
        check({name, " RD_M"}, {27'd0, RD_M}, {27'd0, rd});
        check({name, " RegWriteM"}, {31'd0, RegWriteM}, 32'd1);
        MulDivE = 0;
        model_m = exp;
    endtask

    initial begin
        logic [31:0] a, b, fb_v, e, r1, r2, im, rw, pc;
        logic [2:0]  ctl;
        logic [1:0]  fa, fb, op;
        logic        src, br, jmp;

        vec[0]  = '{3'd0, 2'd0, 2'd1, 1'b0, 32'd5,        32'd99,      32'd0,  32'd7,   32'd12,          32'd7};
        vec[1]  = '{3'd0, 2'd2, 2'd0, 1'b1, 32'd1000,     32'h55,      32'd3,  32'd0,   32'd15,          32'h55};
        vec[2]  = '{3'd1, 2'd0, 2'd0, 1'b0, 32'd3,        32'd5,       32'd0,  32'd0,   32'hFFFF_FFFE,   32'd5};
        vec[3]  = '{3'd2, 2'd0, 2'd0, 1'b0, 32'hF0F0,     32'hFF00,    32'd0,  32'd0,   32'hF000,        32'hFF00};
        vec[4]  = '{3'd3, 2'd0, 2'd0, 1'b0, 32'hF0F0,     32'h0F0F,    32'd0,  32'd0,   32'hFFFF,        32'h0F0F};
        vec[5]  = '{3'd4, 2'd0, 2'd0, 1'b0, 32'hFFFF,     32'h00FF,    32'd0,  32'd0,   32'hFF00,        32'h00FF};
        vec[6]  = '{3'd5, 2'd0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'd1,      32'd0,  32'd0,   32'd1,           32'd1};
        vec[7]  = '{3'd5, 2'd0, 2'd0, 1'b0, 32'd1,        32'hFFFF_FFFF, 32'd0, 32'd0,  32'd0,           32'hFFFF_FFFF};
        vec[8]  = '{3'd6, 2'd0, 2'd0, 1'b0, 32'd8,        32'd9,       32'd0,  32'd0,   32'd0,           32'd9};
        vec[9]  = '{3'd0, 2'd0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'd2,      32'd0,  32'd0,   32'd1,           32'd2};
        vec[10] = '{3'd0, 2'd0, 2'd3, 1'b0, 32'd1,        32'd4,       32'd0,  32'd100, 32'd5,           32'd4};
        vec[11] = '{3'd0, 2'd0, 2'd0, 1'b1, 32'd10,       32'd99,      32'd20, 32'd0,   32'd30,          32'd99};

        // ---- reset state ----
        rst = 1'b0;
        drive_idle();
        PCE = 32'h100; Imm_Ext_E = 32'h20; JumpE = 1; MulDivE = 1;
        #1;
        check("reset ALU_ResultM", ALU_ResultM, 32'd0);
        check("reset WriteDataM", WriteDataM, 32'd0);
        check("reset PCPlus4M", PCPlus4M, 32'd0);
        check("reset ctrl", {27'd0, RegWriteM, MemWriteM, ResultSrcM, 2'd0}, 32'd0);
        check("reset RD_M", {27'd0, RD_M}, 32'd0);
        check("reset BusyE", {31'd0, BusyE}, 32'd0);
        check("reset PCTargetE", PCTargetE, 32'h120);
        MulDivE = 0; #1;
        check("reset PCSrcE", {31'd0, PCSrcE}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        drive_idle();

        // ---- ALU / forwarding table ----
        for (int i = 0; i < 12; i++) begin
            ALUControlE = vec[i].ctl; ForwardA_E = vec[i].fa; ForwardB_E = vec[i].fb;
            ALUSrcE = vec[i].alusrc; RD1_E = vec[i].rd1; RD2_E = vec[i].rd2;
            Imm_Ext_E = vec[i].imm; ResultW = vec[i].resw;
            RD_E = 5'(i + 1); RegWriteE = i[0]; MemWriteE = ~i[0]; ResultSrcE = i[1];
            PCPlus4E = 32'h1000 + 32'(4 * i);
            #1;
            check($sformatf("vec%0d busy", i), {31'd0, BusyE}, 32'd0);
            @(posedge clk); #1;
            check($sformatf("vec%0d alu", i), ALU_ResultM, vec[i].exp_alu);
            check($sformatf("vec%0d wdata", i), WriteDataM, vec[i].exp_wd);
            check($sformatf("vec%0d ctrl", i), {24'd0, RD_M, RegWriteM, MemWriteM, ResultSrcM},
                  {24'd0, 5'(i + 1), i[0], ~i[0], i[1]});
            check($sformatf("vec%0d pc4", i), PCPlus4M, 32'h1000 + 32'(4 * i));
        end
        model_m = vec[11].exp_alu;

        // ---- branch / jump ----
        drive_idle();
        ALUControlE = 3'd1; RD1_E = 9; RD2_E = 9; BranchE = 1; PCE = 32'h100; Imm_Ext_E = 32'h20;
        #1;
        check("beq taken", {31'd0, PCSrcE}, 32'd1);
        check("beq target", PCTargetE, 32'h120);
        RD2_E = 8; #1;
        check("beq not taken", {31'd0, PCSrcE}, 32'd0);
        BranchE = 0; JumpE = 1; #1;
        check("jal taken", {31'd0, PCSrcE}, 32'd1);
        MulDivE = 1; #1;
        check("muldiv blocks redirect", {31'd0, PCSrcE}, 32'd0);
        MulDivE = 0; JumpE = 0;
        @(posedge clk); #1;
        model_m = 32'd1;

        // ---- directed mul/div ----
        run_md(2'd0, 32'd7, 32'd6, 5'd3, 32'd42, "MUL");
        run_md(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, "MULHU");
        run_md(2'd2, 32'd100, 32'd7, 5'd5, 32'd14, "DIVU");
        run_md(2'd3, 32'd100, 32'd7, 5'd6, 32'd2, "REMU");
        run_md(2'd2, 32'h1234, 32'd0, 5'd7, 32'hFFFF_FFFF, "DIVU0");
        run_md(2'd3, 32'h1234, 32'd0, 5'd8, 32'h1234, "REMU0");

        // ---- random mul/div ----
        for (int i = 0; i < 4; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_md(op, a, b, 5'(9 + i), md_ref(op, a, b), $sformatf("rmd%0d", i));
        end

        // ---- random ALU traffic ----
        for (int i = 0; i < 150; i++) begin
            drive_idle();
            ctl = 3'($urandom_range(0, 7));
            fa  = 2'($urandom_range(0, 3));
            fb  = 2'($urandom_range(0, 3));
            src = 1'($urandom_range(0, 1));
            br  = 1'($urandom_range(0, 1));
            jmp = ($urandom_range(0, 3) == 0);
            r1 = $urandom; r2 = $urandom; im = $urandom; rw = $urandom; pc = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                r2 = r1; im = r1; rw = r1;
            end
            ALUControlE = ctl; ForwardA_E = fa; ForwardB_E = fb; ALUSrcE = src;
            BranchE = br; JumpE = jmp; RD1_E = r1; RD2_E = r2; Imm_Ext_E = im;
            ResultW = rw; PCE = pc; RegWriteE = 1; RD_E = 5'(i);
            a    = fwd_ref(fa, r1, rw, model_m);
            fb_v = fwd_ref(fb, r2, rw, model_m);
            b    = src ? im : fb_v;
            e    = alu_ref(ctl, a, b);
            #1;
            check($sformatf("rnd%0d pcsrc", i), {31'd0, PCSrcE},
                  {31'd0, (br && e == 32'd0) || jmp});
            check($sformatf("rnd%0d target", i), PCTargetE, pc + im);
            @(posedge clk); #1;
            check($sformatf("rnd%0d alu", i), ALU_ResultM, e);
            check($sformatf("rnd%0d wdata", i), WriteDataM, fb_v);
            model_m = e;
        end

        // ---- reset during RUN ----
        drive_idle();
        MulDivE = 1; MulDivOpE = 2'd0; RD1_E = 32'd7; RD2_E = 32'd6; RegWriteE = 1; RD_E = 5'd3;
        PCPlus4E = 32'h44;
        #1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("midop busy before reset", {31'd0, BusyE}, 32'd1);
        rst = 1'b0; #1;
        check("midop BusyE", {31'd0, BusyE}, 32'd0);
        check("midop ALU_ResultM", ALU_ResultM, 32'd0);
        check("midop WriteDataM", WriteDataM, 32'd0);
        check("midop PCPlus4M", PCPlus4M, 32'd0);
        check("midop ctrl", {24'd0, RD_M, RegWriteM, MemWriteM, ResultSrcM}, 32'd0);
        MulDivE = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        drive_idle();
        ALUControlE = 3'd0; RD1_E = 32'd2; RD2_E = 32'd3; RegWriteE = 1; RD_E = 5'd7;
        #1;
        check("post-reset busy", {31'd0, BusyE}, 32'd0);
        @(posedge clk); #1;
        check("post-reset add", ALU_ResultM, 32'd5);
        check("post-reset RD_M", {27'd0, RD_M}, 32'd7);
        check("post-reset RegWriteM", {31'd0, RegWriteM}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
